// File: rtl/blink_monitor.sv
// Blink-line monitor: measures the interval between rising edges of blink_in and reports period, lock, mismatch and timeout.
// Define BLINK_MONITOR_TOLERANCE_EN to treat intervals within +/-1 cycle of the previous one as matching.
module blink_monitor #(
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 3,
    parameter int TIMEOUT    = 200
) (
    input  logic             clk,
    input  logic             rstbtn,
    input  logic             blink_in,
    output logic [CNT_W-1:0] period_o,
    output logic             period_valid,
    output logic             locked,
    output logic             mismatch,
    output logic             timeout
);
    localparam logic [1:0]       S_IDLE    = 2'd0;
    localparam logic [1:0]       S_ACQ     = 2'd1;
    localparam logic [1:0]       S_LOCK    = 2'd2;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       LOCK_TGT  = 4'(LOCK_COUNT - 1);

    logic [1:0]       state_q, state_d;
    logic             blink_q, blink_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] prev_q, prev_d;
    logic             prev_ok_q, prev_ok_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pv_q, pv_d;
    logic             locked_q, locked_d;
    logic             mis_q, mis_d;
    logic             tmo_q, tmo_d;

    logic             rise;
    logic             is_match;
    logic [3:0]       match_inc;

    function automatic logic intervals_match(input logic [CNT_W-1:0] a,
                                             input logic [CNT_W-1:0] b);
`ifdef BLINK_MONITOR_TOLERANCE_EN
        logic [CNT_W-1:0] diff;
        diff = (a >= b) ? (a - b) : (b - a);
        return diff <= CNT_ONE;
`else
        return a == b;
`endif
    endfunction

    assign rise      = blink_in & ~blink_q;
    assign is_match  = prev_ok_q & intervals_match(cnt_q, prev_q);
    assign match_inc = match_cnt_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        blink_d     = blink_in;
        cnt_d       = cnt_q;
        prev_d      = prev_q;
        prev_ok_d   = prev_ok_q;
        match_cnt_d = match_cnt_q;
        period_d    = period_q;
        pv_d        = 1'b0;
        locked_d    = locked_q;
        mis_d       = 1'b0;
        tmo_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    cnt_d   = CNT_ONE;
                    state_d = S_ACQ;
                end
            end
            S_ACQ, S_LOCK: begin
                // A rise takes priority over an expiring count, so an interval of exactly TIMEOUT is reported.
                if (rise) begin
                    period_d  = cnt_q;
                    pv_d      = 1'b1;
                    cnt_d     = CNT_ONE;
                    prev_d    = cnt_q;
                    prev_ok_d = 1'b1;
                    if (is_match) begin
                        if (state_q == S_ACQ) begin
                            match_cnt_d = match_inc;
                            if (match_inc >= LOCK_TGT) begin
                                state_d  = S_LOCK;
                                locked_d = 1'b1;
                            end
                        end
                    end else begin
                        match_cnt_d = 4'd0;
                        if (state_q == S_LOCK) begin
                            mis_d    = 1'b1;
                            locked_d = 1'b0;
                            state_d  = S_ACQ;
                        end
                    end
                end else if (cnt_q == TIMEOUT_C) begin
                    tmo_d       = 1'b1;
                    locked_d    = 1'b0;
                    prev_ok_d   = 1'b0;
                    match_cnt_d = 4'd0;
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rstbtn) begin
        if (rstbtn) begin
            state_q     <= S_IDLE;
            blink_q     <= 1'b0;
            cnt_q       <= '0;
            prev_q      <= '0;
            prev_ok_q   <= 1'b0;
            match_cnt_q <= 4'd0;
            period_q    <= '0;
            pv_q        <= 1'b0;
            locked_q    <= 1'b0;
            mis_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            blink_q     <= blink_d;
            cnt_q       <= cnt_d;
            prev_q      <= prev_d;
            prev_ok_q   <= prev_ok_d;
            match_cnt_q <= match_cnt_d;
            period_q    <= period_d;
            pv_q        <= pv_d;
            locked_q    <= locked_d;
            mis_q       <= mis_d;
            tmo_q       <= tmo_d;
        end
    end

    assign period_o     = period_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign mismatch     = mis_q;
    assign timeout      = tmo_q;

endmodule

// File: tb/tb_blink_monitor.sv
// Scoreboard bench for blink_monitor: a timestamp-based model predicts every strobe, a monitor compares what the DUT presents.
module tb_blink_monitor;
    localparam int CNT_W      = 8;
    localparam int LOCK_COUNT = 3;
    localparam int TIMEOUT    = 200;

    logic             clk = 1'b0;
    logic             rstbtn = 1'b1;
    logic             blink_in = 1'b0;
    logic [CNT_W-1:0] period_o;
    logic             period_valid, locked, mismatch, timeout;

    blink_monitor #(.CNT_W(CNT_W), .LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstbtn(rstbtn), .blink_in(blink_in), .period_o(period_o),
        .period_valid(period_valid), .locked(locked), .mismatch(mismatch), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int stamp;
        bit tmo;
        int per;
        bit lck;
        bit mis;
    } ev_t;
    ev_t sbq[$];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: edge times rather than counters.
    bit m_meas, m_bprev, m_have_prev, m_locked;
    int m_last, m_prev, m_streak, m_lastper;

    function automatic bit close_enough(input int a, input int b);
`ifdef BLINK_MONITOR_TOLERANCE_EN
        return (a - b <= 1) && (b - a <= 1);
`else
        return a == b;
`endif
    endfunction

    task automatic model_reset();
        m_meas = 0; m_bprev = 0; m_have_prev = 0; m_locked = 0;
        m_last = 0; m_prev = 0; m_streak = 0; m_lastper = 0;
    endtask

    task automatic model_edge(input bit v, input int stamp);
        bit rise, mt, mis;
        int gap;
        ev_t e;
        rise = v && !m_bprev;
        m_bprev = v;
        if (!m_meas) begin
            if (rise) begin
                m_meas = 1;
                m_last = stamp;
            end
        end else begin
            gap = stamp - m_last;
            if (rise) begin
                m_last = stamp;
                mt = m_have_prev && close_enough(gap, m_prev);
                mis = 0;
                m_streak = mt ? m_streak + 1 : 1;
                if (m_locked && !mt) begin
                    mis = 1;
                    m_locked = 0;
                end else if (!m_locked && m_streak >= LOCK_COUNT) begin
                    m_locked = 1;
                end
                m_prev = gap; m_have_prev = 1; m_lastper = gap;
                e.stamp = stamp; e.tmo = 0; e.per = gap; e.lck = m_locked; e.mis = mis;
                sbq.push_back(e);
            end else if (gap == TIMEOUT) begin
                m_meas = 0; m_have_prev = 0; m_streak = 0; m_locked = 0;
                e.stamp = stamp; e.tmo = 1; e.per = m_lastper; e.lck = 0; e.mis = 0;
                sbq.push_back(e);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step(input bit v);
        blink_in = v;
        model_edge(v, cyc + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n, input int hi);
        for (int k = 0; k < n; k++) step(k < hi);
    endtask

    task automatic lows(input int n);
        for (int k = 0; k < n; k++) step(1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rstbtn = 1'b1;
        blink_in = 1'b1;
        #1;
        chk("rst_period", int'(period_o), 0);
        chk("rst_valid", int'(period_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_mismatch", int'(mismatch), 0);
        chk("rst_timeout", int'(timeout), 0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rstbtn = 1'b0;
        model_reset();
    endtask

    // Monitor: pops the predicted event whenever the DUT strobes or a prediction falls due.
    initial begin
        ev_t e;
        bit have_exp, have_act;
        forever begin
            @(negedge clk);
            if (!rstbtn) begin
                while (sbq.size() > 0 && sbq[0].stamp < cyc) begin
                    e = sbq.pop_front();
                    n_chk++;
                    $display("FAIL missed_event: expected strobe at cycle %0d (tmo=%0b per=%0d) not seen", e.stamp, e.tmo, e.per);
                end
                have_exp = sbq.size() > 0 && sbq[0].stamp == cyc;
                have_act = period_valid || timeout || mismatch;
                if (have_exp || have_act) begin
                    n_chk++;
                    if (!have_exp) begin
                        $display("FAIL unexpected_event: cycle %0d got pv=%0b tmo=%0b mis=%0b per=%0d, expected no strobe",
                                 cyc, period_valid, timeout, mismatch, period_o);
                    end else begin
                        e = sbq.pop_front();
                        if (period_valid == !e.tmo && timeout == e.tmo && int'(period_o) == e.per &&
                            locked == e.lck && mismatch == e.mis)
                            n_pass++;
                        else
                            $display("FAIL event: cycle %0d got pv=%0b tmo=%0b per=%0d lck=%0b mis=%0b, expected pv=%0b tmo=%0b per=%0d lck=%0b mis=%0b",
                                     cyc, period_valid, timeout, period_o, locked, mismatch,
                                     !e.tmo, e.tmo, e.per, e.lck, e.mis);
                    end
                end
            end
        end
    end

    initial begin
        int p, r;
        model_reset();
        do_reset();
        blink_in = 1'b0;

        // Steady 10-cycle train locks after three intervals.
        lows(4);
        repeat (4) gap(10, 3);
        chk("locked_at_10", int'(locked), 1);

        // Step to 5-cycle intervals: mismatch, then relock.
        repeat (5) gap(5, 2);
        chk("relocked_at_5", int'(locked), 1);
        chk("period_5", int'(period_o), 5);

        // Line parked low: timeout, lock dropped.
        lows(210);
        chk("locked_after_timeout", int'(locked), 0);
        chk("period_kept", int'(period_o), 5);

        // Wide high pulses: one rise per level.
        repeat (5) gap(12, 7);
        chk("period_12", int'(period_o), 12);

        // Alternating 10/11 intervals.
        lows(210);
        gap(10, 2); gap(11, 2); gap(10, 2); gap(11, 2); gap(10, 2);
`ifdef BLINK_MONITOR_TOLERANCE_EN
        chk("jitter_lock", int'(locked), 1);
`else
        chk("jitter_lock", int'(locked), 0);
`endif

        // Interval exactly TIMEOUT is reported; one more cycle times out.
        lows(210);
        gap(TIMEOUT, 1); gap(TIMEOUT, 1); gap(3, 1);
        chk("period_timeout_edge", int'(period_o), TIMEOUT);
        gap(TIMEOUT + 1, 1); gap(3, 1);

        // Reset while locked, released with the line high.
        repeat (4) gap(6, 2);
        lows(2);
        chk("locked_before_reset", int'(locked), 1);
        do_reset();
        step(1'b1);
        chk("no_valid_after_reset", int'(period_valid), 0);
        lows(5);
        step(1'b1);
        chk("first_period_after_reset", int'(period_o), 6);
        lows(3);

        // Randomized trains with occasional long gaps around TIMEOUT.
        for (int i = 0; i < 60; i++) begin
            p = $urandom_range(2, 9);
            r = $urandom_range(1, 5);
            repeat (r) gap(p, $urandom_range(1, p - 1));
            if ($urandom_range(0, 9) == 0) lows($urandom_range(TIMEOUT - 3, TIMEOUT + 2));
        end

        lows(5);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
